// File: rtl/turn_scheduler_if.sv
// rtl/turn_scheduler_if.sv - byte-wide serial link channel of the turn scheduler
// Purpose: bundles the UART TX handshake and the RX byte strobe.
// Signals:
//   tx_byte  [7:0]  byte towards UART TX, held stable while tx_valid && !tx_ready
//   tx_valid        TX byte valid
//   tx_ready        UART TX accepts the byte this cycle
//   rx_byte  [7:0]  byte from UART RX
//   rx_valid        1-cycle strobe, rx_byte valid
// Modports: master = scheduler side, slave = UART side.
interface turn_scheduler_if;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_byte;
  logic       rx_valid;

  modport master (output tx_byte, output tx_valid, input tx_ready,
                  input rx_byte, input rx_valid);
  modport slave  (input tx_byte, input tx_valid, output tx_ready,
                  output rx_byte, output rx_valid);
endinterface

// File: rtl/turn_scheduler.sv
// rtl/turn_scheduler.sv - shot/answer turn sequencer between local board and remote peer
// Purpose: after placement, synchronises with the peer ('R' frames), then alternates
//   shooting rights, sends 'S' shots, answers incoming shots with 'A' frames after a
//   board lookup, counts hits and declares win/lose. Timeouts and protocol
//   violations end in a sticky link error.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start_i, set_player_i      placement done pulse, 1 = local player shoots first
//   shot_valid_i, shot_pos_i   local shot request {row,col}; shot_ready_o accepts it
//   link_if                    UART TX handshake and RX strobe (master modport)
//   query_pos_o, query_valid_o board lookup strobe; query_hit_i one cycle later
//   your_turn_o                local player may shoot
//   result_valid_o/hit_o/pos_o answer to our shot
//   enemy_valid_o/hit_o/pos_o  resolved enemy shot
//   win_o, lose_o, link_error_o sticky end flags
//   state_led_o                current state encoding
module turn_scheduler #(
  parameter int TIMEOUT_CYCLES = 130_000_000,
  parameter int SHIP_CELLS     = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             set_player_i,
  input  logic             shot_valid_i,
  input  logic [7:0]       shot_pos_i,
  output logic             shot_ready_o,
  turn_scheduler_if.master link_if,
  output logic [7:0]       query_pos_o,
  output logic             query_valid_o,
  input  logic             query_hit_i,
  output logic             your_turn_o,
  output logic             result_valid_o,
  output logic             result_hit_o,
  output logic [7:0]       result_pos_o,
  output logic             enemy_valid_o,
  output logic             enemy_hit_o,
  output logic [7:0]       enemy_pos_o,
  output logic             win_o,
  output logic             lose_o,
  output logic             link_error_o,
  output logic [3:0]       state_led_o
);

  localparam logic [7:0] OP_R = 8'h52;
  localparam logic [7:0] OP_S = 8'h53;
  localparam logic [7:0] OP_A = 8'h41;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'h0,
    ST_SYNC       = 4'h1,
    ST_MY_TURN    = 4'h2,
    ST_SEND_SHOT  = 4'h3,
    ST_WAIT_ANS   = 4'h4,
    ST_THEIR_TURN = 4'h5,
    ST_LOOKUP     = 4'h6,
    ST_SEND_ANS   = 4'h7,
    ST_DONE       = 4'h8,
    ST_ERROR      = 4'hF
  } state_e;

  state_e      state_q, state_d;
  logic        first_q, first_d;
  logic        r_sent_q, r_sent_d;
  logic        r_rcvd_q, r_rcvd_d;
  logic [26:0] to_q, to_d;
  logic        rx_phase_q, rx_phase_d;
  logic [7:0]  rx_op_q, rx_op_d;
  logic        buf_full_q, buf_full_d;
  logic [7:0]  buf_op_q, buf_op_d;
  logic [7:0]  buf_pay_q, buf_pay_d;
  logic        tx_busy_q, tx_busy_d;
  logic        tx_phase_q, tx_phase_d;
  logic [7:0]  tx_op_q, tx_op_d;
  logic [7:0]  tx_pay_q, tx_pay_d;
  logic [7:0]  shot_pos_q, shot_pos_d;
  logic        query_valid_q, query_valid_d;
  logic [7:0]  query_pos_q, query_pos_d;
  logic        result_valid_q, result_valid_d;
  logic        result_hit_q, result_hit_d;
  logic        enemy_valid_q, enemy_valid_d;
  logic        enemy_hit_q, enemy_hit_d;
  logic [4:0]  my_hits_q, my_hits_d;
  logic [4:0]  their_hits_q, their_hits_d;
  logic        win_q, win_d;
  logic        lose_q, lose_d;
  logic        err_q, err_d;

  logic        frame_done, buf_pop, overflow, go_err, timeout;
  logic        tx_start, tx_fire, tx_done;
  logic [7:0]  tx_op_n, tx_pay_n;
  logic [4:0]  my_hits_inc, their_hits_inc;

  // RX parser: a byte that is not a known opcode in phase 0 is dropped so the
  // parser resynchronises on the next opcode.
  always_comb begin
    rx_phase_d = rx_phase_q;
    rx_op_d    = rx_op_q;
    frame_done = 1'b0;
    if (link_if.rx_valid) begin
      if (!rx_phase_q) begin
        if (link_if.rx_byte == OP_R || link_if.rx_byte == OP_S || link_if.rx_byte == OP_A) begin
          rx_op_d    = link_if.rx_byte;
          rx_phase_d = 1'b1;
        end
      end else begin
        rx_phase_d = 1'b0;
        frame_done = 1'b1;
      end
    end
  end

  // One-deep frame buffer; a pop and a new frame in the same cycle is legal.
  assign overflow = frame_done && buf_full_q && !buf_pop;

  always_comb begin
    buf_full_d = buf_full_q;
    buf_op_d   = buf_op_q;
    buf_pay_d  = buf_pay_q;
    if (buf_pop) buf_full_d = 1'b0;
    if (frame_done && (!buf_full_q || buf_pop)) begin
      buf_full_d = 1'b1;
      buf_op_d   = rx_op_q;
      buf_pay_d  = link_if.rx_byte;
    end
  end

  // TX engine: the FSM only requests a frame while the engine is idle.
  assign tx_fire = tx_busy_q && link_if.tx_ready;
  assign tx_done = tx_fire && tx_phase_q;

  always_comb begin
    tx_busy_d  = tx_busy_q;
    tx_phase_d = tx_phase_q;
    tx_op_d    = tx_op_q;
    tx_pay_d   = tx_pay_q;
    if (tx_start) begin
      tx_busy_d  = 1'b1;
      tx_phase_d = 1'b0;
      tx_op_d    = tx_op_n;
      tx_pay_d   = tx_pay_n;
    end else if (tx_fire) begin
      if (tx_phase_q) tx_busy_d = 1'b0;
      else            tx_phase_d = 1'b1;
    end
  end

  assign timeout        = (to_q == 27'(TIMEOUT_CYCLES - 1));
  assign my_hits_inc    = (my_hits_q == 5'h1F) ? my_hits_q : my_hits_q + 5'd1;
  assign their_hits_inc = (their_hits_q == 5'h1F) ? their_hits_q : their_hits_q + 5'd1;

  always_comb begin
    state_d        = state_q;
    first_d        = first_q;
    r_sent_d       = r_sent_q;
    r_rcvd_d       = r_rcvd_q;
    buf_pop        = 1'b0;
    tx_start       = 1'b0;
    tx_op_n        = OP_R;
    tx_pay_n       = 8'h00;
    shot_pos_d     = shot_pos_q;
    query_valid_d  = 1'b0;
    query_pos_d    = query_pos_q;
    result_valid_d = 1'b0;
    result_hit_d   = result_hit_q;
    enemy_valid_d  = 1'b0;
    enemy_hit_d    = enemy_hit_q;
    my_hits_d      = my_hits_q;
    their_hits_d   = their_hits_q;
    win_d          = win_q;
    lose_d         = lose_q;
    err_d          = err_q;
    go_err         = 1'b0;

    case (state_q)
      // Frames arriving before start (e.g. the peer's 'R') stay buffered.
      ST_IDLE: begin
        if (start_i) begin
          first_d  = set_player_i;
          r_sent_d = 1'b0;
          r_rcvd_d = 1'b0;
          tx_start = 1'b1;
          state_d  = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (tx_done) r_sent_d = 1'b1;
        if (buf_full_q) begin
          buf_pop = 1'b1;
          if (buf_op_q == OP_R) r_rcvd_d = 1'b1;
          else                  go_err   = 1'b1;
        end
        if (r_sent_d && r_rcvd_d) state_d = first_q ? ST_MY_TURN : ST_THEIR_TURN;
        else if (timeout)         go_err  = 1'b1;
      end
      ST_MY_TURN: begin
        if (shot_valid_i) begin
          shot_pos_d = shot_pos_i;
          tx_start   = 1'b1;
          tx_op_n    = OP_S;
          tx_pay_n   = shot_pos_i;
          state_d    = ST_SEND_SHOT;
        end
      end
      ST_SEND_SHOT: begin
        if (tx_done) state_d = ST_WAIT_ANS;
      end
      ST_WAIT_ANS: begin
        if (buf_full_q) begin
          buf_pop = 1'b1;
          if (buf_op_q == OP_A) begin
            result_valid_d = 1'b1;
            result_hit_d   = buf_pay_q[0];
            if (buf_pay_q[0]) begin
              my_hits_d = my_hits_inc;
              if (my_hits_inc == 5'(SHIP_CELLS)) begin
                win_d   = 1'b1;
                state_d = ST_DONE;
              end else begin
                state_d = ST_MY_TURN;
              end
            end else begin
              state_d = ST_THEIR_TURN;
            end
          end else if (buf_op_q == OP_S) begin
            go_err = 1'b1;
          end
        end else if (timeout) begin
          go_err = 1'b1;
        end
      end
      ST_THEIR_TURN: begin
        if (buf_full_q) begin
          buf_pop = 1'b1;
          if (buf_op_q == OP_S) begin
            query_valid_d = 1'b1;
            query_pos_d   = buf_pay_q;
            state_d       = ST_LOOKUP;
          end else if (buf_op_q == OP_A) begin
            go_err = 1'b1;
          end
        end
      end
      // First LOOKUP cycle carries the query strobe; the board answers in the second.
      ST_LOOKUP: begin
        if (!query_valid_q) begin
          enemy_valid_d = 1'b1;
          enemy_hit_d   = query_hit_i;
          tx_start      = 1'b1;
          tx_op_n       = OP_A;
          tx_pay_n      = {7'b0, query_hit_i};
          state_d       = ST_SEND_ANS;
        end
      end
      ST_SEND_ANS: begin
        if (tx_done) begin
          if (enemy_hit_q) begin
            their_hits_d = their_hits_inc;
            if (their_hits_inc == 5'(SHIP_CELLS)) begin
              lose_d  = 1'b1;
              state_d = ST_DONE;
            end else begin
              state_d = ST_THEIR_TURN;
            end
          end else begin
            state_d = ST_MY_TURN;
          end
        end
      end
      // DONE/ERROR: absorbing, incoming frames are discarded.
      default: begin
        if (buf_full_q) buf_pop = 1'b1;
      end
    endcase

    if (go_err || overflow) begin
      err_d   = 1'b1;
      state_d = ST_ERROR;
    end
  end

  assign to_d = (state_d != state_q) ? 27'd0 : to_q + 27'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      first_q        <= 1'b0;
      r_sent_q       <= 1'b0;
      r_rcvd_q       <= 1'b0;
      to_q           <= 27'd0;
      rx_phase_q     <= 1'b0;
      rx_op_q        <= 8'h00;
      buf_full_q     <= 1'b0;
      buf_op_q       <= 8'h00;
      buf_pay_q      <= 8'h00;
      tx_busy_q      <= 1'b0;
      tx_phase_q     <= 1'b0;
      tx_op_q        <= 8'h00;
      tx_pay_q       <= 8'h00;
      shot_pos_q     <= 8'h00;
      query_valid_q  <= 1'b0;
      query_pos_q    <= 8'h00;
      result_valid_q <= 1'b0;
      result_hit_q   <= 1'b0;
      enemy_valid_q  <= 1'b0;
      enemy_hit_q    <= 1'b0;
      my_hits_q      <= 5'd0;
      their_hits_q   <= 5'd0;
      win_q          <= 1'b0;
      lose_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      first_q        <= first_d;
      r_sent_q       <= r_sent_d;
      r_rcvd_q       <= r_rcvd_d;
      to_q           <= to_d;
      rx_phase_q     <= rx_phase_d;
      rx_op_q        <= rx_op_d;
      buf_full_q     <= buf_full_d;
      buf_op_q       <= buf_op_d;
      buf_pay_q      <= buf_pay_d;
      tx_busy_q      <= tx_busy_d;
      tx_phase_q     <= tx_phase_d;
      tx_op_q        <= tx_op_d;
      tx_pay_q       <= tx_pay_d;
      shot_pos_q     <= shot_pos_d;
      query_valid_q  <= query_valid_d;
      query_pos_q    <= query_pos_d;
      result_valid_q <= result_valid_d;
      result_hit_q   <= result_hit_d;
      enemy_valid_q  <= enemy_valid_d;
      enemy_hit_q    <= enemy_hit_d;
      my_hits_q      <= my_hits_d;
      their_hits_q   <= their_hits_d;
      win_q          <= win_d;
      lose_q         <= lose_d;
      err_q          <= err_d;
    end
  end

  assign link_if.tx_valid = tx_busy_q;
  assign link_if.tx_byte  = tx_busy_q ? (tx_phase_q ? tx_pay_q : tx_op_q) : 8'h00;
  assign shot_ready_o     = (state_q == ST_MY_TURN);
  assign your_turn_o      = (state_q == ST_MY_TURN);
  assign query_valid_o    = query_valid_q;
  assign query_pos_o      = query_pos_q;
  assign result_valid_o   = result_valid_q;
  assign result_hit_o     = result_hit_q;
  assign result_pos_o     = shot_pos_q;
  assign enemy_valid_o    = enemy_valid_q;
  assign enemy_hit_o      = enemy_hit_q;
  assign enemy_pos_o      = query_pos_q;
  assign win_o            = win_q;
  assign lose_o           = lose_q;
  assign link_error_o     = err_q;
  assign state_led_o      = state_q;

endmodule

// File: tb/tb_turn_scheduler.sv
// tb/tb_turn_scheduler.sv - self-checking bench for turn_scheduler with a game-level peer model
module tb_turn_scheduler;
  localparam int TO    = 100;
  localparam int SHIPS = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, set_player, shot_valid, query_hit;
  logic [7:0] shot_pos;
  logic       shot_ready, query_valid, your_turn, result_valid, result_hit;
  logic       enemy_valid, enemy_hit, win, lose, link_error;
  logic [7:0] query_pos, result_pos, enemy_pos;
  logic [3:0] state_led;

  turn_scheduler_if bus ();

  turn_scheduler #(.TIMEOUT_CYCLES(TO), .SHIP_CELLS(SHIPS)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .set_player_i(set_player),
    .shot_valid_i(shot_valid), .shot_pos_i(shot_pos), .shot_ready_o(shot_ready),
    .link_if(bus), .query_pos_o(query_pos), .query_valid_o(query_valid),
    .query_hit_i(query_hit), .your_turn_o(your_turn), .result_valid_o(result_valid),
    .result_hit_o(result_hit), .result_pos_o(result_pos), .enemy_valid_o(enemy_valid),
    .enemy_hit_o(enemy_hit), .enemy_pos_o(enemy_pos), .win_o(win), .lose_o(lose),
    .link_error_o(link_error), .state_led_o(state_led)
  );

  int   compared = 0;
  int   mismatched = 0;
  int   ready_mode = 1;
  logic manual_ready = 1'b0;

  // TX ready driver: 0 always ready, 1 random, 2 never, 3 manual.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       bus.tx_ready = 1'b1;
      1:       bus.tx_ready = 1'($urandom_range(0, 1));
      2:       bus.tx_ready = 1'b0;
      default: bus.tx_ready = manual_ready;
    endcase
  end

  logic [7:0] tx_log[$];
  logic [8:0] res_log[$];
  logic [8:0] en_log[$];
  logic [7:0] qry_log[$];
  int tx_rd = 0, res_rd = 0, en_rd = 0, qry_rd = 0;

  always @(negedge clk) begin
    if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) tx_log.push_back(bus.tx_byte);
    if (result_valid === 1'b1) res_log.push_back({result_hit, result_pos});
    if (enemy_valid === 1'b1)  en_log.push_back({enemy_hit, enemy_pos});
    if (query_valid === 1'b1)  qry_log.push_back(query_pos);
  end

  // Game model: expected state code derived from hit tallies and whose turn it is.
  int m_my = 0, m_their = 0;
  logic [3:0] m_state = 4'h0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {17'b0, shot_ready, bus.tx_byte, bus.tx_valid, query_pos, query_valid, your_turn,
            result_valid, result_hit, result_pos, enemy_valid, enemy_hit, enemy_pos,
            win, lose, link_error, state_led};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_byte = b; bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] pay);
    send_byte(op);
    repeat (3) @(posedge clk);
    send_byte(pay);
  endtask

  task automatic wait_state(input logic [3:0] st);
    for (int i = 0; i < 400 && state_led !== st; i++) @(negedge clk);
  endtask

  task automatic expect_tx(input string tag, input logic [7:0] b0, input logic [7:0] b1);
    logic [7:0] g0, g1;
    for (int i = 0; i < 400 && (tx_log.size() - tx_rd) < 2; i++) @(negedge clk);
    g0 = 8'hxx; g1 = 8'hxx;
    if (tx_log.size() - tx_rd >= 2) begin
      g0 = tx_log[tx_rd]; g1 = tx_log[tx_rd + 1]; tx_rd += 2;
    end
    check({tag, "_byte0"}, 64'(g0), 64'(b0));
    check({tag, "_byte1"}, 64'(g1), 64'(b1));
  endtask

  task automatic start_game(input logic sp);
    @(negedge clk);
    set_player = sp; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_my = 0; m_their = 0;
  endtask

  task automatic my_shot(input logic [7:0] pos, input logic hit);
    logic [8:0] got;
    wait_state(4'h2);
    check("my_turn_flag", 64'(your_turn), 64'd1);
    check("shot_ready", 64'(shot_ready), 64'd1);
    shot_valid = 1'b1; shot_pos = pos;
    @(negedge clk);
    shot_valid = 1'b0;
    check("turn_drop", 64'(your_turn), 64'd0);
    expect_tx("shot", 8'h53, pos);
    send_frame(8'h41, {7'b0, hit});
    for (int i = 0; i < 400 && res_log.size() <= res_rd; i++) @(negedge clk);
    got = 9'bx;
    if (res_log.size() > res_rd) begin got = res_log[res_rd]; res_rd++; end
    check("result", 64'(got), 64'({hit, pos}));
    if (hit) begin
      m_my++;
      m_state = (m_my == SHIPS) ? 4'h8 : 4'h2;
    end else begin
      m_state = 4'h5;
    end
    @(negedge clk);
    check("state_after_answer", 64'(state_led), 64'(m_state));
  endtask

  task automatic their_shot(input logic [7:0] pos, input logic hit);
    logic [8:0] e;
    logic [7:0] q;
    wait_state(4'h5);
    query_hit = hit;
    send_frame(8'h53, pos);
    for (int i = 0; i < 400 && qry_log.size() <= qry_rd; i++) @(negedge clk);
    q = 8'hxx;
    if (qry_log.size() > qry_rd) begin q = qry_log[qry_rd]; qry_rd++; end
    check("query_pos", 64'(q), 64'(pos));
    for (int i = 0; i < 400 && en_log.size() <= en_rd; i++) @(negedge clk);
    e = 9'bx;
    if (en_log.size() > en_rd) begin e = en_log[en_rd]; en_rd++; end
    check("enemy", 64'(e), 64'({hit, pos}));
    expect_tx("answer", 8'h41, {7'b0, hit});
    @(negedge clk);
    if (hit) begin
      m_their++;
      m_state = (m_their == SHIPS) ? 4'h8 : 4'h5;
    end else begin
      m_state = 4'h2;
    end
    check("state_after_enemy", 64'(state_led), 64'(m_state));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_outputs", outs(), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tx_rd = tx_log.size(); res_rd = res_log.size();
    en_rd = en_log.size(); qry_rd = qry_log.size();
    m_state = 4'h0;
  endtask

  initial begin
    logic stable;
    rst_n = 1'b0; start = 1'b0; set_player = 1'b0; shot_valid = 1'b0; shot_pos = 8'h00;
    query_hit = 1'b0; bus.rx_byte = 8'h00; bus.rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", outs(), 64'd0);
    rst_n = 1'b1;

    // T1: local first, peer 'R' arrives later
    start_game(1'b1);
    check("sync_state", 64'(state_led), 64'h1);
    expect_tx("ready", 8'h52, 8'h00);
    repeat (10) @(negedge clk);
    check("still_sync", 64'(state_led), 64'h1);
    send_frame(8'h52, 8'h00);
    wait_state(4'h2);
    check("t1_state", 64'(state_led), 64'h2);
    check("t1_your_turn", 64'(your_turn), 64'd1);
    m_state = 4'h2;

    // T2/T3 directed exchanges
    my_shot(8'h34, 1'b1);
    my_shot(8'($urandom), 1'b0);
    their_shot(8'h27, 1'b1);
    their_shot(8'($urandom), 1'b0);

    // Game 1: board never hit after T3, random answers -> local win
    for (int it = 0; it < 200 && m_state != 4'h8; it++) begin
      if (m_state == 4'h2) my_shot(8'($urandom), 1'($urandom_range(0, 1)));
      else                 their_shot(8'($urandom), 1'b0);
    end
    check("t4_win", 64'(win), 64'd1);
    check("t4_not_lose", 64'(lose), 64'd0);
    send_frame(8'h53, 8'h11);
    send_frame(8'h41, 8'h01);
    repeat (20) @(negedge clk);
    check("t4_done_state", 64'(state_led), 64'h8);
    check("t4_no_turn", 64'(your_turn), 64'd0);
    check("t4_no_error", 64'(link_error), 64'd0);
    check("t4_no_query", 64'(qry_log.size() - qry_rd), 64'd0);

    // Game 2: junk byte then peer 'R' while idle, peer first, our shots always miss -> lose
    do_reset();
    send_byte(8'h99);
    send_frame(8'h52, 8'h00);
    repeat (3) @(negedge clk);
    check("idle_hold", 64'(state_led), 64'h0);
    start_game(1'b0);
    expect_tx("ready2", 8'h52, 8'h00);
    wait_state(4'h5);
    check("g2_their_turn", 64'(state_led), 64'h5);
    m_state = 4'h5;
    for (int it = 0; it < 200 && m_state != 4'h8; it++) begin
      if (m_state == 4'h2) my_shot(8'($urandom), 1'b0);
      else                 their_shot(8'($urandom), 1'($urandom_range(0, 99) < 60));
    end
    check("g2_lose", 64'(lose), 64'd1);
    check("g2_not_win", 64'(win), 64'd0);
    check("g2_done", 64'(state_led), 64'h8);

    // T5: no answer -> timeout
    do_reset();
    start_game(1'b1);
    expect_tx("ready3", 8'h52, 8'h00);
    send_frame(8'h52, 8'h00);
    wait_state(4'h2);
    shot_valid = 1'b1; shot_pos = 8'h5A;
    @(negedge clk);
    shot_valid = 1'b0;
    expect_tx("t5_shot", 8'h53, 8'h5A);
    wait_state(4'h4);
    repeat (95) @(negedge clk);
    check("t5_pre_state", 64'(state_led), 64'h4);
    check("t5_pre_err", 64'(link_error), 64'd0);
    repeat (10) @(negedge clk);
    check("t5_err", 64'(link_error), 64'd1);
    check("t5_state", 64'(state_led), 64'hF);

    // T6: TX stall mid-frame, then reset mid-frame
    do_reset();
    start_game(1'b1);
    expect_tx("ready4", 8'h52, 8'h00);
    send_frame(8'h52, 8'h00);
    wait_state(4'h2);
    manual_ready = 1'b0; ready_mode = 3;
    shot_valid = 1'b1; shot_pos = 8'hC3;
    @(negedge clk);
    shot_valid = 1'b0;
    for (int i = 0; i < 50 && bus.tx_valid !== 1'b1; i++) @(negedge clk);
    check("t6_byte0", 64'(bus.tx_byte), 64'h53);
    manual_ready = 1'b1;
    @(negedge clk);
    manual_ready = 1'b0;
    @(negedge clk);
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (bus.tx_byte !== 8'hC3 || bus.tx_valid !== 1'b1) stable = 1'b0;
      @(negedge clk);
    end
    check("t6_hold", 64'(stable), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t6_reset_outputs", outs(), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
